// File: rtl/dram_pingpong_buffer.sv
// Dual-bank ping-pong word buffer for the CNN controller's two DRAM ports.
// After reset both banks are zeroed, then each port owns one bank until a swap exchanges them.
module dram_pingpong_buffer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p1_en,
  input  logic              p1_wen,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  input  logic              p2_en,
  input  logic              p2_wen,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_wdata,
  output logic [DATA_W-1:0] p2_rdata,
  output logic              p2_rvalid,
  input  logic              swap,
  output logic              bank_sel,
  output logic              ready,
  output logic              err_oob
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic              p1_ok, p2_ok;
  logic [CNT_W-1:0]  p1_idx, p2_idx;
  logic              a_we, b_we;
  logic [CNT_W-1:0]  a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;

  assign p1_ok  = {1'b0, p1_addr} < LIMIT;
  assign p2_ok  = {1'b0, p2_addr} < LIMIT;
  assign p1_idx = CNT_W'(p1_addr);
  assign p2_idx = CNT_W'(p2_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      CLEAR: if (clr_cnt == CNT_W'(DEPTH-1)) next_state = RUN;
      RUN:   ready = 1'b1;
      default: next_state = CLEAR;
    endcase
  end

  // Bank write ports: the clear sequencer owns both banks, otherwise bank_sel routes the ports
  always_comb begin
    a_we    = 1'b0;
    b_we    = 1'b0;
    a_addr  = clr_cnt;
    b_addr  = clr_cnt;
    a_wdata = '0;
    b_wdata = '0;
    if (state == CLEAR) begin
      a_we = 1'b1;
      b_we = 1'b1;
    end else if (!bank_sel) begin
      a_we    = p1_en & p1_wen & p1_ok;
      a_addr  = p1_idx;
      a_wdata = p1_wdata;
      b_we    = p2_en & p2_wen & p2_ok;
      b_addr  = p2_idx;
      b_wdata = p2_wdata;
    end else begin
      a_we    = p2_en & p2_wen & p2_ok;
      a_addr  = p2_idx;
      a_wdata = p2_wdata;
      b_we    = p1_en & p1_wen & p1_ok;
      b_addr  = p1_idx;
      b_wdata = p1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_wdata;
    if (b_we) mem_b[b_addr] <= b_wdata;
  end

  // Reads use the mapping in force during the request cycle, so a swap-cycle read sees the old bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_rdata  <= '0;
      p2_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p2_rvalid <= 1'b0;
      bank_sel  <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      p1_rvalid <= 1'b0;
      p2_rvalid <= 1'b0;
      if (state == RUN) begin
        if (p1_en && !p1_wen) begin
          p1_rvalid <= 1'b1;
          p1_rdata  <= !p1_ok ? '0 : (bank_sel ? mem_b[p1_idx] : mem_a[p1_idx]);
        end
        if (p2_en && !p2_wen) begin
          p2_rvalid <= 1'b1;
          p2_rdata  <= !p2_ok ? '0 : (bank_sel ? mem_a[p2_idx] : mem_b[p2_idx]);
        end
        if ((p1_en && !p1_ok) || (p2_en && !p2_ok))
          err_oob <= 1'b1;
        if (swap)
          bank_sel <= ~bank_sel;
      end
    end
  end

endmodule

// File: tb/tb_dram_pingpong_buffer.sv
// Self-checking bench for dram_pingpong_buffer: directed plan steps plus random traffic
// compared against a two-bank array model with an explicit mapping bit.
module tb_dram_pingpong_buffer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4240;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              p1_en = 1'b0, p1_wen = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [DATA_W-1:0] p1_wdata = '0;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;
  logic              p2_en = 1'b0, p2_wen = 1'b0;
  logic [ADDR_W-1:0] p2_addr = '0;
  logic [DATA_W-1:0] p2_wdata = '0;
  logic [DATA_W-1:0] p2_rdata;
  logic              p2_rvalid;
  logic              swap = 1'b0;
  logic              bank_sel, ready, err_oob;

  int checks = 0;
  int errors = 0;

  // Reference model: model[k] is the bank that port 1 sees when sel == k
  logic [DATA_W-1:0] model [2][DEPTH];
  int                sel;
  logic              oob_flag;
  logic [DATA_W-1:0] exp_rd1, exp_rd2;
  logic              exp_rv1, exp_rv2;

  dram_pingpong_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p1_en(p1_en), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .p2_en(p2_en), .p2_wen(p2_wen), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_rdata(p2_rdata), .p2_rvalid(p2_rvalid),
    .swap(swap), .bank_sel(bank_sel), .ready(ready), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    p1_en = 1'b0; p1_wen = 1'b0; p1_addr = '0; p1_wdata = '0;
    p2_en = 1'b0; p2_wen = 1'b0; p2_addr = '0; p2_wdata = '0;
    swap  = 1'b0;
  endtask

  // One RUN cycle: drive, predict from pre-edge model state, clock, check, then update the model
  task automatic step(input logic e1, input logic w1, input int a1, input logic [DATA_W-1:0] d1,
                      input logic e2, input logic w2, input int a2, input logic [DATA_W-1:0] d2,
                      input logic sw);
    p1_en = e1; p1_wen = w1; p1_addr = ADDR_W'(a1); p1_wdata = d1;
    p2_en = e2; p2_wen = w2; p2_addr = ADDR_W'(a2); p2_wdata = d2;
    swap  = sw;
    exp_rv1 = e1 && !w1;
    exp_rv2 = e2 && !w2;
    if (exp_rv1) exp_rd1 = (a1 < DEPTH) ? model[sel][a1] : '0;
    if (exp_rv2) exp_rd2 = (a2 < DEPTH) ? model[1-sel][a2] : '0;
    @(posedge clk); #1;
    if (e1 && w1 && a1 < DEPTH) model[sel][a1] = d1;
    if (e2 && w2 && a2 < DEPTH) model[1-sel][a2] = d2;
    if ((e1 && a1 >= DEPTH) || (e2 && a2 >= DEPTH)) oob_flag = 1'b1;
    if (sw) sel = 1 - sel;
    check_bit ("p1_rvalid", p1_rvalid, exp_rv1);
    check_word("p1_rdata",  p1_rdata,  exp_rd1);
    check_bit ("p2_rvalid", p2_rvalid, exp_rv2);
    check_word("p2_rdata",  p2_rdata,  exp_rd2);
    check_bit ("bank_sel",  bank_sel,  sel[0]);
    check_bit ("err_oob",   err_oob,   oob_flag);
    check_bit ("ready",     ready,     1'b1);
    idle_inputs();
  endtask

  // Reset, verify cleared outputs, then run the clear phase with junk requests that must be ignored
  task automatic do_reset();
    int cyc;
    idle_inputs();
    reset = 1'b1;
    #2;
    check_word("rst p1_rdata", p1_rdata, '0);
    check_word("rst p2_rdata", p2_rdata, '0);
    check_bit ("rst p1_rvalid", p1_rvalid, 1'b0);
    check_bit ("rst p2_rvalid", p2_rvalid, 1'b0);
    check_bit ("rst bank_sel", bank_sel, 1'b0);
    check_bit ("rst ready", ready, 1'b0);
    check_bit ("rst err_oob", err_oob, 1'b0);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) model[b][i] = '0;
    sel = 0; oob_flag = 1'b0; exp_rd1 = '0; exp_rd2 = '0;
    @(negedge clk);
    reset = 1'b0;
    p1_en = 1'b1; p1_wen = 1'b1; p1_addr = 13'd3; p1_wdata = 16'hFFFF;
    p2_en = 1'b1; p2_wen = 1'b0; p2_addr = 13'd7000;
    swap  = 1'b1;
    cyc = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
    end
    check_word("clear length", 16'(cyc), 16'(DEPTH));
    check_bit ("clear p1_rvalid", p1_rvalid, 1'b0);
    check_bit ("clear p2_rvalid", p2_rvalid, 1'b0);
    check_bit ("clear bank_sel", bank_sel, 1'b0);
    check_bit ("clear err_oob", err_oob, 1'b0);
    idle_inputs();
  endtask

  initial begin
    do_reset();

    // Cleared contents, including the junk write to addr 3 during CLEAR
    step(1, 0, 0, 0,      1, 0, 100, 0,  0);
    step(1, 0, DEPTH-1, 0, 1, 0, 3, 0,   0);
    step(1, 0, 3, 0,      0, 0, 0, 0,    0);

    // Basic write/read and bank separation
    step(1, 1, 5, 16'h1234, 0, 0, 0, 0,  0);
    step(1, 0, 5, 0,      1, 0, 5, 0,    0);

    // Swap remaps banks
    step(1, 1, 7, 16'hAAAA, 0, 0, 0, 0,  0);
    step(0, 0, 0, 0,      0, 0, 0, 0,    1);
    step(1, 0, 7, 0,      1, 0, 7, 0,    0);
    step(0, 0, 0, 0,      0, 0, 0, 0,    1);

    // Swap-cycle read uses the old mapping, the next one the new
    step(1, 0, 5, 0,      0, 0, 0, 0,    1);
    step(1, 0, 5, 0,      0, 0, 0, 0,    0);

    // Out-of-range write dropped, read returns zero, flag is sticky
    step(0, 0, 0, 0,      1, 1, DEPTH, 16'hFFFF, 0);
    step(0, 0, 0, 0,      1, 0, DEPTH, 0, 0);
    step(1, 0, DEPTH-4096, 0, 1, 0, DEPTH-4096, 0, 0);
    step(0, 0, 0, 0,      0, 0, 0, 0,    0);

    // Random traffic over a small window so reads hit earlier writes
    for (int n = 0; n < 400; n++) begin
      int a1, a2;
      a1 = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 50)) : int'($urandom_range(0, 15));
      a2 = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 50)) : int'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a2, 16'($urandom),
           $urandom_range(0, 7) == 0);
    end

    // Mid-run reset restarts the clear and wipes everything
    do_reset();
    step(1, 0, 5, 0,      1, 0, 5, 0,    0);
    step(1, 0, 7, 0,      1, 0, 7, 0,    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_pingpong_buffer.md
Name: dram_pingpong_buffer

Overview:
Dual-bank ping-pong DRAM buffer that sits directly downstream of CNN_controller and serves its two DRAM request packs (DRAM_in1/DRAM_in2 → DRAM_out1/DRAM_out2). One controller port is mapped to each bank. A swap pulse exchanges the bank roles, so one layer's output buffer becomes the next layer's input buffer. After reset, a clear sequencer zeroes both banks before `ready` is asserted.

Parameters:
ADDR_W, 13, address width per port (matches DRAMA_DIM)
DATA_W, 16, data word width
DEPTH, 4240, words per bank; valid addresses are 0..DEPTH-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
p1_en  in  1  port-1 request valid (DRAM_in1)
p1_wen  in  1  port-1 write enable: 1 = write, 0 = read
p1_addr  in  ADDR_W  port-1 address
p1_wdata  in  DATA_W  port-1 write data
p1_rdata  out  DATA_W  port-1 read data (DRAM_out1.Data)
p1_rvalid  out  1  port-1 read data valid
p2_en  in  1  port-2 request valid (DRAM_in2)
p2_wen  in  1  port-2 write enable
p2_addr  in  ADDR_W  port-2 address
p2_wdata  in  DATA_W  port-2 write data
p2_rdata  out  DATA_W  port-2 read data (DRAM_out2.Data)
p2_rvalid  out  1  port-2 read data valid
swap  in  1  single-cycle pulse that exchanges the bank mapping
bank_sel  out  1  current mapping: 0 = p1→bank A, p2→bank B; 1 = p1→bank B, p2→bank A
ready  out  1  high once the clear sequence is done and requests are accepted
err_oob  out  1  sticky out-of-range access flag

Behaviour:
- Reset (asynchronous, active-high):
  - p1_rdata/p2_rdata = 0, p1_rvalid/p2_rvalid = 0, bank_sel = 0, ready = 0, err_oob = 0.
  - FSM = CLEAR, clear counter = 0.
  - Memory contents are not reset asynchronously; the CLEAR state zeroes them.
- FSM has two states: CLEAR and RUN.
- CLEAR:
  - Each cycle writes 0 to address clr_cnt in both banks, then increments clr_cnt.
  - When clr_cnt = DEPTH-1 is written, the next state is RUN.
  - CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - ready goes high on the first RUN cycle.
  - All port requests and swap are ignored; rvalid stays 0.
- RUN:
  - Stays in RUN until reset.
  - Reset asserted mid-run aborts everything in flight and restarts CLEAR; bank_sel returns to 0.
- Bank mapping: the two ports always address different banks, so there are no inter-port conflicts.
- Write (en=1, wen=1, addr<DEPTH): data is committed at the clock edge. A read of the same address on a later cycle returns the new data.
- Read (en=1, wen=0, addr<DEPTH):
  - Request at cycle N → rdata = mem[addr] and rvalid = 1 at cycle N+1 (one-cycle latency).
  - rvalid is high for exactly one cycle per read; back-to-back reads give back-to-back valid data.
  - rdata holds its last value while rvalid = 0.
- Write cycles never assert rvalid.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped; memory is unchanged.
  - Read returns rdata = 0 with rvalid = 1 at N+1.
  - err_oob is set and stays high until reset.
- Swap:
  - swap=1 in RUN toggles bank_sel at the clock edge.
  - A request issued in the swap cycle uses the old mapping, including its returning read data at N+1.
  - Requests from N+1 onward use the new mapping.
  - swap held high toggles bank_sel every cycle, with no debounce.
- Simultaneous write and read of the same address on the same port cannot occur (one request per port per cycle).

Test Plan:
1. Clear sequence: deassert reset → ready = 0 for exactly 4240 cycles, then 1. A p1 read of addr 0 and addr 4239, and a p2 read of addr 100, all return 0x0000 with rvalid one cycle later.
2. Basic write/read: p1 writes addr 5 = 0x1234; p1 reads addr 5 next cycle → p1_rdata = 0x1234 and p1_rvalid = 1 exactly one cycle after the read request. p2 reads addr 5 → 0x0000 (other bank).
3. Swap: p1 writes addr 7 = 0xAAAA, then swap is pulsed → bank_sel = 1. p2 reads addr 7 → 0xAAAA; p1 reads addr 7 → 0x0000. A second swap pulse → bank_sel = 0.
4. Swap-cycle read: p1 reads addr 5 in the same cycle as the swap pulse (bank A holds 0x1234) → returns 0x1234. The same p1 read one cycle later returns bank B's value.
5. Out-of-range: p2 writes addr 4240 = 0xFFFF → err_oob = 1 and sticky. p2 reads addr 4240 → rdata = 0, rvalid = 1. Memory is unchanged.
6. Mid-run reset: after the writes above, assert reset for one cycle → all outputs return to 0, including ready. After 4240 cycles ready = 1, addr 5 and addr 7 read 0 on both ports, bank_sel = 0, err_oob = 0.
